ripple_carry_counter_sync: RTL and testbench

// - Free-running binary up-counter, modulo 2**WIDTH, built as a chain of toggle stages.
// - Stage i toggles when all lower stages are 1, i.e. the synchronous equivalent of a ripple chain.
// - Basic counting/timebase block; the 4-bit default is used as the introductory counter example.
// - Output q is the registered count value.
//

---
 rtl/ripple_carry_counter_sync.sv | 34 +++
 tb/tb_ripple_carry_counter_sync.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ripple_carry_counter_sync.sv
// Free-running modulo-2**WIDTH up-counter built from per-bit toggle stages.
// All state changes on the falling edge of clk; reset is synchronous, active-high.
module ripple_carry_counter_sync #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] toggle_s;

  // Stage i toggles only when every lower stage is already 1.
  assign toggle_s[0] = 1'b1;

  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
      assign toggle_s[i] = &count_r[i-1:0];
    end
  endgenerate

  // Toggle-flop bank; reset takes priority over counting.
  always_ff @(negedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_r ^ toggle_s;
    end
  end

  assign q = count_r;

endmodule

// File: tb/tb_ripple_carry_counter_sync.sv
// Bench for ripple_carry_counter_sync: table-driven vectors, hand sequences and
// randomized reset traffic checked against an integer counting model, at WIDTH 1, 4 and 8.
module tb_ripple_carry_counter_sync;

  logic       clk;
  logic       reset;
  logic [3:0] q4;
  logic [7:0] q8;
  logic [0:0] q1;

  int n_compared;
  int n_mismatched;
  int unsigned cnt;

  ripple_carry_counter_sync #(.WIDTH(4)) dut4 (.q(q4), .clk(clk), .reset(reset));
  ripple_carry_counter_sync #(.WIDTH(8)) dut8 (.q(q8), .clk(clk), .reset(reset));
  ripple_carry_counter_sync #(.WIDTH(1)) dut1 (.q(q1), .clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    int   exp4;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One falling edge: optional reset pulse straddling the rising edge in between.
  task automatic do_edge(input logic rst_v, input logic glitch);
    if (glitch) reset = 1'b1;
    @(posedge clk);
    #2;
    if (glitch) begin
      check("rise_q4", int'(q4), int'(cnt % 16));
      reset = 1'b0;
    end else begin
      reset = rst_v;
    end
    @(negedge clk);
    #1;
    if (rst_v && !glitch) cnt = 0;
    else cnt = cnt + 1;
    check("model_q4", int'(q4), int'(cnt % 16));
    check("model_q8", int'(q8), int'(cnt % 256));
    check("model_q1", int'(q1), int'(cnt % 2));
  endtask

  initial begin
    int exp_list [25];
    n_compared   = 0;
    n_mismatched = 0;
    cnt          = 0;
    reset        = 1'b1;

    // Edges at t=10..250: power-up reset at t=10, mid-run reset at t=200.
    exp_list = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                 0, 1, 2, 0, 1, 2, 3, 4, 5};
    for (int i = 0; i < 25; i++) begin
      vecs[i].rst  = (i == 0 || i == 19) ? 1'b1 : 1'b0;
      vecs[i].exp4 = exp_list[i];
    end

    for (int i = 0; i < 25; i++) begin
      do_edge(vecs[i].rst, 1'b0);
      check("table_q4", int'(q4), vecs[i].exp4);
    end

    // Reset pulse between falling edges must not disturb the count.
    for (int i = 0; i < 3; i++) begin
      do_edge(1'b0, 1'b1);
    end

    // Reset held for 5 falling edges, then the first count gives 1.
    for (int i = 0; i < 5; i++) begin
      do_edge(1'b1, 1'b0);
      check("held_q4", int'(q4), 0);
    end
    do_edge(1'b0, 1'b0);
    check("release_q4", int'(q4), 1);
    check("release_q8", int'(q8), 1);

    // Randomized reset and glitch traffic.
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic g;
      r = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      g = (!r && $urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      do_edge(r, g);
    end

    // 8-bit wrap: 255 then 0; 1-bit alternation rides along.
    do_edge(1'b1, 1'b0);
    check("wrap_start_q8", int'(q8), 0);
    for (int i = 0; i < 255; i++) begin
      do_edge(1'b0, 1'b0);
    end
    check("wrap_top_q8", int'(q8), 255);
    check("wrap_top_q4", int'(q4), 15);
    check("wrap_top_q1", int'(q1), 1);
    do_edge(1'b0, 1'b0);
    check("wrap_zero_q8", int'(q8), 0);
    check("wrap_zero_q4", int'(q4), 0);
    check("wrap_zero_q1", int'(q1), 0);
    do_edge(1'b0, 1'b0);
    check("wrap_one_q8", int'(q8), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
